// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg: state encodings, size codes and the lane-select size encoder.
package data_sram_bridge_pkg;
    localparam int REG_WIDTH = 32;
    localparam int DATA_SIZE_WIDTH = 2;

    typedef enum logic [2:0] {
        DRAM_IDLE = 3'd0,
        DRAM_ADDR = 3'd1,
        DRAM_DATA = 3'd2,
        DRAM_DONE = 3'd3,
        DRAM_DROP = 3'd4
    } dram_state_t;

    localparam logic [DATA_SIZE_WIDTH-1:0] DSIZE_B = 2'd0;
    localparam logic [DATA_SIZE_WIDTH-1:0] DSIZE_H = 2'd1;
    localparam logic [DATA_SIZE_WIDTH-1:0] DSIZE_W = 2'd2;

    function automatic logic [DATA_SIZE_WIDTH-1:0] size_of(input logic [3:0] sel);
        logic one_hot;
        one_hot = (sel != 4'b0) && ((sel & (sel - 4'd1)) == 4'b0);
        return (sel == 4'b1111) ? DSIZE_W :
               (sel == 4'b1100 || sel == 4'b0011) ? DSIZE_H :
               one_hot ? DSIZE_B : DSIZE_W;
    endfunction
endpackage

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: runs one memory-stage RAM request as an SRAM-like bus transaction
// (address + data handshake) and pauses the pipeline until the access completes.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ram_en_i,
    input  logic                       mem_write_en_i,
    input  logic [REG_WIDTH-1:0]       mem_addr_i,
    input  logic [REG_WIDTH-1:0]       store_data_i,
    input  logic [3:0]                 mem_select_i,
    input  logic                       excp_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    output logic [REG_WIDTH-1:0]       ram_data_o,
    output logic                       pause_dram_o,
    output logic                       data_req_o,
    output logic                       data_wr_o,
    output logic [DATA_SIZE_WIDTH-1:0] data_size_o,
    output logic [3:0]                 data_wstrb_o,
    output logic [REG_WIDTH-1:0]       data_addr_o,
    output logic [REG_WIDTH-1:0]       data_wdata_o,
    input  logic                       data_addr_ok_i,
    input  logic                       data_data_ok_i,
    input  logic [REG_WIDTH-1:0]       data_rdata_i
);
    dram_state_t          state, next;
    logic                 cancel;
    logic [REG_WIDTH-1:0] rbuf;
    logic                 issue, cancelled;

    // ram_en_i is ignored while reset is asserted so nothing reaches the bus
    assign issue     = rst & ram_en_i & ~excp_i & ~flush_i;
    assign cancelled = cancel | flush_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= DRAM_IDLE;
            cancel <= 1'b0;
            rbuf   <= '0;
        end else begin
            state  <= next;
            cancel <= (next == DRAM_IDLE) ? 1'b0 :
                      ((state == DRAM_ADDR || state == DRAM_DATA) && flush_i) ? 1'b1 : cancel;
            if (state == DRAM_DATA && data_data_ok_i)
                rbuf <= mem_write_en_i ? '0 : data_rdata_i;
        end
    end

    always_comb begin
        next = state;
        case (state)
            DRAM_IDLE: next = issue ? (data_addr_ok_i ? DRAM_DATA : DRAM_ADDR) : DRAM_IDLE;
            DRAM_ADDR: next = data_addr_ok_i ? DRAM_DATA : DRAM_ADDR;
            DRAM_DATA: next = cancelled ? (data_data_ok_i ? DRAM_IDLE : DRAM_DROP)
                                        : (data_data_ok_i ? DRAM_DONE : DRAM_DATA);
            DRAM_DONE: next = (~stall_i | flush_i) ? DRAM_IDLE : DRAM_DONE;
            DRAM_DROP: next = data_data_ok_i ? DRAM_IDLE : DRAM_DROP;
            default:   next = DRAM_IDLE;
        endcase
    end

    always_comb begin
        data_req_o   = rst & ((state == DRAM_IDLE && issue) || state == DRAM_ADDR);
        pause_dram_o = rst & ((state == DRAM_IDLE && issue) ||
                       ((state == DRAM_ADDR || state == DRAM_DATA) && !cancelled) ||
                       (state == DRAM_DROP && ram_en_i));
        ram_data_o   = (state == DRAM_DONE) ? rbuf : '0;
        data_wr_o    = mem_write_en_i;
        data_addr_o  = mem_addr_i;
        data_wdata_o = store_data_i;
        data_wstrb_o = mem_write_en_i ? mem_select_i : 4'b0;
        data_size_o  = size_of(mem_select_i);
    end
endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge: directed scenarios for the memory-stage to SRAM bus bridge.
module tb_data_sram_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en_i, mem_write_en_i, excp_i, flush_i, stall_i;
    logic [31:0] mem_addr_i, store_data_i, data_rdata_i;
    logic [3:0]  mem_select_i;
    logic [31:0] ram_data_o, data_addr_o, data_wdata_o;
    logic        pause_dram_o, data_req_o, data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic        data_addr_ok_i, data_data_ok_i;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_sram_bridge dut (
        .clk(clk), .rst(rst), .ram_en_i(ram_en_i), .mem_write_en_i(mem_write_en_i),
        .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .mem_select_i(mem_select_i),
        .excp_i(excp_i), .flush_i(flush_i), .stall_i(stall_i), .ram_data_o(ram_data_o),
        .pause_dram_o(pause_dram_o), .data_req_o(data_req_o), .data_wr_o(data_wr_o),
        .data_size_o(data_size_o), .data_wstrb_o(data_wstrb_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_addr_ok_i(data_addr_ok_i),
        .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        ram_en_i = 0; mem_write_en_i = 0; mem_addr_i = 0; store_data_i = 0; mem_select_i = 0;
        excp_i = 0; flush_i = 0; stall_i = 0; data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
    endtask

    task automatic test_reset;
        quiet();
        rst = 0; ram_en_i = 1; mem_select_i = 4'b1111;
        @(negedge clk);
        n_cmp++; if (data_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", data_req_o); end
        n_cmp++; if (pause_dram_o !== 1'b0) begin n_bad++; $display("FAIL reset_pause got %b want 0", pause_dram_o); end
        tick();
        ram_en_i = 0; rst = 1;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o, ram_data_o} !== 34'h0) begin n_bad++;
            $display("FAIL reset_idle got req=%b pause=%b rdata=%h want 0/0/0", data_req_o, pause_dram_o, ram_data_o); end
        tick();
    endtask

    task automatic test_size;
        logic [3:0] sel [7] = '{4'b1111, 4'b1100, 4'b0011, 4'b0001, 4'b1000, 4'b0110, 4'b0000};
        logic [1:0] exp [7] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
        quiet();
        mem_write_en_i = 1;
        for (int i = 0; i < 7; i++) begin
            mem_select_i = sel[i];
            #1;
            n_cmp++; if (data_size_o !== exp[i] || data_wstrb_o !== sel[i]) begin n_bad++;
                $display("FAIL size sel=%b got size=%0d wstrb=%b want size=%0d wstrb=%b",
                         sel[i], data_size_o, data_wstrb_o, exp[i], sel[i]); end
        end
        quiet();
        tick();
    endtask

    task automatic test_load_word;
        quiet();
        ram_en_i = 1; mem_addr_i = 32'h1000; mem_select_i = 4'b1111; data_addr_ok_i = 1;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o, data_wr_o, data_size_o, data_wstrb_o, data_addr_o} !== {3'b110, 2'd2, 4'b0, 32'h1000}) begin n_bad++;
            $display("FAIL lw_c0 got req=%b pause=%b wr=%b size=%0d wstrb=%b addr=%h want 1/1/0/2/0000/1000",
                     data_req_o, pause_dram_o, data_wr_o, data_size_o, data_wstrb_o, data_addr_o); end
        tick(); data_addr_ok_i = 0;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b01) begin n_bad++;
            $display("FAIL lw_c1 got req=%b pause=%b want 0/1", data_req_o, pause_dram_o); end
        tick(); data_data_ok_i = 1; data_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o, ram_data_o} !== {2'b01, 32'h0}) begin n_bad++;
            $display("FAIL lw_c2 got req=%b pause=%b rdata=%h want 0/1/0", data_req_o, pause_dram_o, ram_data_o); end
        tick(); data_data_ok_i = 0; data_rdata_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== {1'b0, 32'hDEADBEEF}) begin n_bad++;
            $display("FAIL lw_c3 got pause=%b rdata=%h want 0/deadbeef", pause_dram_o, ram_data_o); end
        tick(); ram_en_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== 33'h0) begin n_bad++;
            $display("FAIL lw_after got pause=%b rdata=%h want 0/0", pause_dram_o, ram_data_o); end
        tick();
    endtask

    task automatic test_store_byte;
        quiet();
        ram_en_i = 1; mem_write_en_i = 1; mem_addr_i = 32'h2001; store_data_i = 32'h5A5A5A5A; mem_select_i = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok_i = (i == 3);
            @(negedge clk);
            n_cmp++; if ({data_req_o, pause_dram_o, data_wr_o, data_size_o, data_wstrb_o, data_addr_o, data_wdata_o}
                         !== {3'b111, 2'd0, 4'b0100, 32'h2001, 32'h5A5A5A5A}) begin n_bad++;
                $display("FAIL sb_req%0d got req=%b pause=%b wr=%b size=%0d wstrb=%b addr=%h wdata=%h want 1/1/1/0/0100/2001/5a5a5a5a",
                         i, data_req_o, pause_dram_o, data_wr_o, data_size_o, data_wstrb_o, data_addr_o, data_wdata_o); end
            tick();
        end
        data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b01) begin n_bad++;
            $display("FAIL sb_data got req=%b pause=%b want 0/1", data_req_o, pause_dram_o); end
        tick(); data_data_ok_i = 0; data_rdata_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== 33'h0) begin n_bad++;
            $display("FAIL sb_done got pause=%b rdata=%h want 0/0", pause_dram_o, ram_data_o); end
        tick(); quiet();
        tick();
    endtask

    task automatic test_excp;
        quiet();
        ram_en_i = 1; excp_i = 1; mem_select_i = 4'b1111; data_addr_ok_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b00) begin n_bad++;
                $display("FAIL excp%0d got req=%b pause=%b want 0/0", i, data_req_o, pause_dram_o); end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_flush_drop;
        quiet();
        ram_en_i = 1; mem_addr_i = 32'h3000; mem_select_i = 4'b1111; data_addr_ok_i = 1;
        tick(); data_addr_ok_i = 0; flush_i = 1;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b00) begin n_bad++;
            $display("FAIL fl_data got req=%b pause=%b want 0/0", data_req_o, pause_dram_o); end
        tick(); flush_i = 0; mem_addr_i = 32'h4000;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b01) begin n_bad++;
            $display("FAIL fl_drop got req=%b pause=%b want 0/1", data_req_o, pause_dram_o); end
        tick(); data_data_ok_i = 1; data_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o, ram_data_o} !== {2'b01, 32'h0}) begin n_bad++;
            $display("FAIL fl_dropok got req=%b pause=%b rdata=%h want 0/1/0", data_req_o, pause_dram_o, ram_data_o); end
        tick(); data_data_ok_i = 0; data_rdata_i = 0; data_addr_ok_i = 1;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o, data_addr_o, ram_data_o} !== {2'b11, 32'h4000, 32'h0}) begin n_bad++;
            $display("FAIL fl_reissue got req=%b pause=%b addr=%h rdata=%h want 1/1/4000/0",
                     data_req_o, pause_dram_o, data_addr_o, ram_data_o); end
        tick(); data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'h12345678;
        tick(); data_data_ok_i = 0; data_rdata_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== {1'b0, 32'h12345678}) begin n_bad++;
            $display("FAIL fl_newdone got pause=%b rdata=%h want 0/12345678", pause_dram_o, ram_data_o); end
        tick(); quiet();
        tick();
    endtask

    task automatic test_stall_done;
        quiet();
        ram_en_i = 1; mem_addr_i = 32'h5000; mem_select_i = 4'b1111; data_addr_ok_i = 1;
        tick(); data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'hCAFEF00D;
        tick(); data_data_ok_i = 0; data_rdata_i = 0; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({data_req_o, pause_dram_o, ram_data_o} !== {2'b00, 32'hCAFEF00D}) begin n_bad++;
                $display("FAIL stall%0d got req=%b pause=%b rdata=%h want 0/0/cafef00d", i, data_req_o, pause_dram_o, ram_data_o); end
            tick();
        end
        stall_i = 0;
        @(negedge clk);
        n_cmp++; if (ram_data_o !== 32'hCAFEF00D) begin n_bad++;
            $display("FAIL stall_release got rdata=%h want cafef00d", ram_data_o); end
        tick(); ram_en_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== 33'h0) begin n_bad++;
            $display("FAIL stall_idle got pause=%b rdata=%h want 0/0", pause_dram_o, ram_data_o); end
        tick();
    endtask

    task automatic test_addr_data_same;
        quiet();
        ram_en_i = 1; mem_addr_i = 32'h6000; mem_select_i = 4'b0011;
        tick(); data_addr_ok_i = 1; data_data_ok_i = 1; data_rdata_i = 32'h1111;
        tick(); data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o, ram_data_o} !== {2'b01, 32'h0}) begin n_bad++;
            $display("FAIL same_wait got req=%b pause=%b rdata=%h want 0/1/0", data_req_o, pause_dram_o, ram_data_o); end
        tick(); data_data_ok_i = 1; data_rdata_i = 32'h2222;
        tick(); data_data_ok_i = 0; data_rdata_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== {1'b0, 32'h2222}) begin n_bad++;
            $display("FAIL same_done got pause=%b rdata=%h want 0/00002222", pause_dram_o, ram_data_o); end
        tick(); quiet();
        tick();
    endtask

    task automatic test_reset_mid;
        quiet();
        ram_en_i = 1; mem_addr_i = 32'h7000; mem_select_i = 4'b1111;
        tick();
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b11) begin n_bad++;
            $display("FAIL rm_addr got req=%b pause=%b want 1/1", data_req_o, pause_dram_o); end
        rst = 0;
        tick(); rst = 1; ram_en_i = 0;
        @(negedge clk);
        n_cmp++; if ({data_req_o, pause_dram_o} !== 2'b00) begin n_bad++;
            $display("FAIL rm_idle got req=%b pause=%b want 0/0", data_req_o, pause_dram_o); end
        data_data_ok_i = 1; data_rdata_i = 32'h777;
        tick(); data_data_ok_i = 0; data_rdata_i = 0;
        @(negedge clk);
        n_cmp++; if ({pause_dram_o, ram_data_o} !== 33'h0) begin n_bad++;
            $display("FAIL rm_stray got pause=%b rdata=%h want 0/0", pause_dram_o, ram_data_o); end
        tick();
    endtask

    initial begin
        quiet();
        rst = 0;
        #1;
        test_reset();
        test_size();
        test_load_word();
        test_store_byte();
        test_excp();
        test_flush_drop();
        test_stall_done();
        test_addr_data_same();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
